// File: rtl/axis_burst_counter.sv
// AXI-Stream ramp generator: emits bursts of cfg_limit beats counting from
// cfg_start by cfg_step, either back-to-back (FREE) or one burst per trig rising edge (TRIGGERED).
module axis_burst_counter #(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH       = 32,
  parameter string MODE             = "FREE"
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_enbl,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_start,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_step,
  input  logic [CNTR_WIDTH-1:0]       cfg_limit,
  input  logic [CNTR_WIDTH-1:0]       cfg_bursts,
  input  logic                        trig,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [CNTR_WIDTH-1:0]       sts_bursts,
  output logic                        sts_busy,
  output logic                        sts_done
);

  localparam bit TRIG_MODE = (MODE == "TRIGGERED");

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                      state_r;
  logic                        trig_reg_r;
  logic                        trig_prev_r;
  logic [CNTR_WIDTH-1:0]       bursts_r;
  logic [AXIS_TDATA_WIDTH-1:0] step_r;
  logic [CNTR_WIDTH-1:0]       limit_r;
  logic [CNTR_WIDTH-1:0]       beat_r;

  logic                        trig_edge_s;
  logic                        handshake_s;
  logic [CNTR_WIDTH-1:0]       beat_next_s;
  logic [CNTR_WIDTH-1:0]       sts_next_s;
  logic                        run_done_s;

  assign trig_edge_s = trig_reg_r & ~trig_prev_r;
  assign handshake_s = m_axis_tvalid & m_axis_tready;
  assign beat_next_s = beat_r + CNTR_WIDTH'(1);
  assign sts_next_s  = sts_bursts + CNTR_WIDTH'(1);
  // A zero burst count means the run never finishes on its own.
  assign run_done_s  = (bursts_r != CNTR_WIDTH'(0)) && (sts_next_s == bursts_r);

  // Burst FSM with trigger synchroniser; every output is driven from this register stage.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r       <= IDLE;
      trig_reg_r    <= 1'b0;
      trig_prev_r   <= 1'b0;
      bursts_r      <= CNTR_WIDTH'(0);
      step_r        <= AXIS_TDATA_WIDTH'(0);
      limit_r       <= CNTR_WIDTH'(0);
      beat_r        <= CNTR_WIDTH'(0);
      m_axis_tdata  <= AXIS_TDATA_WIDTH'(0);
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sts_bursts    <= CNTR_WIDTH'(0);
      sts_busy      <= 1'b0;
      sts_done      <= 1'b0;
    end else begin
      trig_reg_r  <= trig;
      trig_prev_r <= trig_reg_r;
      case (state_r)
        IDLE: begin
          if (cfg_enbl && (cfg_limit != CNTR_WIDTH'(0))) begin
            bursts_r   <= cfg_bursts;
            sts_bursts <= CNTR_WIDTH'(0);
            sts_busy   <= 1'b1;
            sts_done   <= 1'b0;
            if (TRIG_MODE) begin
              state_r <= WAIT;
            end else begin
              state_r       <= RUN;
              step_r        <= cfg_step;
              limit_r       <= cfg_limit;
              beat_r        <= CNTR_WIDTH'(0);
              m_axis_tdata  <= cfg_start;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= (cfg_limit == CNTR_WIDTH'(1));
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (!cfg_enbl) begin
            state_r  <= IDLE;
            sts_busy <= 1'b0;
          end else if (trig_edge_s) begin
            state_r       <= RUN;
            step_r        <= cfg_step;
            limit_r       <= cfg_limit;
            beat_r        <= CNTR_WIDTH'(0);
            m_axis_tdata  <= cfg_start;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (cfg_limit == CNTR_WIDTH'(1));
          end else begin
            state_r <= WAIT;
          end
        end
        RUN: begin
          if (handshake_s) begin
            if (m_axis_tlast) begin
              sts_bursts <= sts_next_s;
            end else begin
              sts_bursts <= sts_bursts;
            end
            // A disable only lands on a handshake so the beat in flight is never withdrawn.
            if (!cfg_enbl) begin
              state_r       <= IDLE;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              sts_busy      <= 1'b0;
            end else if (!m_axis_tlast) begin
              beat_r       <= beat_next_s;
              m_axis_tdata <= m_axis_tdata + step_r;
              m_axis_tlast <= (beat_next_s == (limit_r - CNTR_WIDTH'(1)));
            end else if (run_done_s) begin
              state_r       <= DONE;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              sts_busy      <= 1'b0;
              sts_done      <= 1'b1;
            end else if (TRIG_MODE) begin
              state_r       <= WAIT;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
            end else begin
              step_r       <= cfg_step;
              limit_r      <= cfg_limit;
              beat_r       <= CNTR_WIDTH'(0);
              m_axis_tdata <= cfg_start;
              m_axis_tlast <= (cfg_limit == CNTR_WIDTH'(1));
            end
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (!cfg_enbl) begin
            state_r  <= IDLE;
            sts_done <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r       <= IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          sts_busy      <= 1'b0;
          sts_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_burst_counter.sv
// Directed bench for axis_burst_counter: FREE 32-bit, TRIGGERED 32-bit and FREE 8-bit instances.
module tb_axis_burst_counter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        en_a, en_b, en_c;
  logic [31:0] cfg_start, cfg_step, cfg_limit, cfg_bursts;
  logic        trig, tready;

  logic [31:0] a_tdata, a_cnt, b_tdata, b_cnt, c_cnt;
  logic [7:0]  c_tdata;
  logic        a_tvalid, a_tlast, a_busy, a_done;
  logic        b_tvalid, b_tlast, b_busy, b_done;
  logic        c_tvalid, c_tlast, c_busy, c_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axis_burst_counter #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .MODE("FREE")) dut_a (
    .aclk(aclk), .areset(areset), .cfg_enbl(en_a), .cfg_start(cfg_start), .cfg_step(cfg_step),
    .cfg_limit(cfg_limit), .cfg_bursts(cfg_bursts), .trig(trig), .m_axis_tdata(a_tdata),
    .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast), .m_axis_tready(tready),
    .sts_bursts(a_cnt), .sts_busy(a_busy), .sts_done(a_done));

  axis_burst_counter #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .MODE("TRIGGERED")) dut_b (
    .aclk(aclk), .areset(areset), .cfg_enbl(en_b), .cfg_start(cfg_start), .cfg_step(cfg_step),
    .cfg_limit(cfg_limit), .cfg_bursts(cfg_bursts), .trig(trig), .m_axis_tdata(b_tdata),
    .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast), .m_axis_tready(tready),
    .sts_bursts(b_cnt), .sts_busy(b_busy), .sts_done(b_done));

  axis_burst_counter #(.AXIS_TDATA_WIDTH(8), .CNTR_WIDTH(32), .MODE("FREE")) dut_c (
    .aclk(aclk), .areset(areset), .cfg_enbl(en_c), .cfg_start(cfg_start[7:0]), .cfg_step(cfg_step[7:0]),
    .cfg_limit(cfg_limit), .cfg_bursts(cfg_bursts), .trig(trig), .m_axis_tdata(c_tdata),
    .m_axis_tvalid(c_tvalid), .m_axis_tlast(c_tlast), .m_axis_tready(tready),
    .sts_bursts(c_cnt), .sts_busy(c_busy), .sts_done(c_done));

  typedef struct {
    logic        en;
    logic        rdy;
    logic [31:0] lim;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        eb;
    logic        edn;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vt[42];

  function automatic vec_t mk(input logic en, input logic rdy, input int lim, input logic ev,
                              input int ed, input logic el, input logic eb, input logic edn,
                              input int ecnt);
    vec_t v;
    v.en = en; v.rdy = rdy; v.lim = 32'(lim); v.ev = ev; v.ed = 32'(ed);
    v.el = el; v.eb = eb; v.edn = edn; v.ecnt = 32'(ecnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // FREE start=10 step=3 bursts=2: ready=1 run, done, toggled-ready run, limit=1, limit=0, enable drop
    vt[0]  = mk(1'b1, 1'b1, 4, 1'b1, 10, 1'b0, 1'b1, 1'b0, 0);
    vt[1]  = mk(1'b1, 1'b1, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 0);
    vt[2]  = mk(1'b1, 1'b1, 4, 1'b1, 16, 1'b0, 1'b1, 1'b0, 0);
    vt[3]  = mk(1'b1, 1'b1, 4, 1'b1, 19, 1'b1, 1'b1, 1'b0, 0);
    vt[4]  = mk(1'b1, 1'b1, 4, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1);
    vt[5]  = mk(1'b1, 1'b1, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 1);
    vt[6]  = mk(1'b1, 1'b1, 4, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1);
    vt[7]  = mk(1'b1, 1'b1, 4, 1'b1, 19, 1'b1, 1'b1, 1'b0, 1);
    vt[8]  = mk(1'b1, 1'b1, 4, 1'b0, 0,  1'b0, 1'b0, 1'b1, 2);
    vt[9]  = mk(1'b1, 1'b1, 4, 1'b0, 0,  1'b0, 1'b0, 1'b1, 2);
    vt[10] = mk(1'b0, 1'b1, 4, 1'b0, 0,  1'b0, 1'b0, 1'b0, 2);
    vt[11] = mk(1'b1, 1'b0, 4, 1'b1, 10, 1'b0, 1'b1, 1'b0, 0);
    vt[12] = mk(1'b1, 1'b0, 4, 1'b1, 10, 1'b0, 1'b1, 1'b0, 0);
    vt[13] = mk(1'b1, 1'b1, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 0);
    vt[14] = mk(1'b1, 1'b0, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 0);
    vt[15] = mk(1'b1, 1'b0, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 0);
    vt[16] = mk(1'b1, 1'b1, 4, 1'b1, 16, 1'b0, 1'b1, 1'b0, 0);
    vt[17] = mk(1'b1, 1'b1, 4, 1'b1, 19, 1'b1, 1'b1, 1'b0, 0);
    vt[18] = mk(1'b1, 1'b0, 4, 1'b1, 19, 1'b1, 1'b1, 1'b0, 0);
    vt[19] = mk(1'b1, 1'b1, 4, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1);
    vt[20] = mk(1'b1, 1'b1, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 1);
    vt[21] = mk(1'b1, 1'b0, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 1);
    vt[22] = mk(1'b1, 1'b1, 4, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1);
    vt[23] = mk(1'b1, 1'b1, 4, 1'b1, 19, 1'b1, 1'b1, 1'b0, 1);
    vt[24] = mk(1'b1, 1'b0, 4, 1'b1, 19, 1'b1, 1'b1, 1'b0, 1);
    vt[25] = mk(1'b1, 1'b1, 4, 1'b0, 0,  1'b0, 1'b0, 1'b1, 2);
    vt[26] = mk(1'b0, 1'b1, 4, 1'b0, 0,  1'b0, 1'b0, 1'b0, 2);
    vt[27] = mk(1'b1, 1'b1, 1, 1'b1, 10, 1'b1, 1'b1, 1'b0, 0);
    vt[28] = mk(1'b1, 1'b1, 1, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1);
    vt[29] = mk(1'b1, 1'b1, 1, 1'b0, 0,  1'b0, 1'b0, 1'b1, 2);
    vt[30] = mk(1'b0, 1'b1, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0, 2);
    vt[31] = mk(1'b1, 1'b1, 0, 1'b0, 0,  1'b0, 1'b0, 1'b0, 2);
    vt[32] = mk(1'b1, 1'b1, 0, 1'b0, 0,  1'b0, 1'b0, 1'b0, 2);
    vt[33] = mk(1'b1, 1'b1, 4, 1'b1, 10, 1'b0, 1'b1, 1'b0, 0);
    vt[34] = mk(1'b1, 1'b1, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 35; i < 40; i++) vt[i] = mk(1'b0, 1'b0, 4, 1'b1, 13, 1'b0, 1'b1, 1'b0, 0);
    vt[40] = mk(1'b0, 1'b1, 4, 1'b0, 0,  1'b0, 1'b0, 1'b0, 0);
    vt[41] = mk(1'b0, 1'b1, 4, 1'b0, 0,  1'b0, 1'b0, 1'b0, 0);

    areset = 1'b1; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; trig = 1'b0; tready = 1'b0;
    cfg_start = 32'd10; cfg_step = 32'd3; cfg_limit = 32'd4; cfg_bursts = 32'd2;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_tvalid", 32'(a_tvalid), 32'd0);
    chk("reset_tdata", a_tdata, 32'd0);
    chk("reset_tlast", 32'(a_tlast), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_done", 32'(a_done), 32'd0);
    chk("reset_bursts", a_cnt, 32'd0);
    areset = 1'b0;

    for (int i = 0; i < 42; i++) begin
      en_a = vt[i].en; tready = vt[i].rdy; cfg_limit = vt[i].lim;
      @(posedge aclk);
      #1;
      chk($sformatf("vec%0d_tvalid", i), 32'(a_tvalid), 32'(vt[i].ev));
      if (vt[i].ev) chk($sformatf("vec%0d_tdata", i), a_tdata, vt[i].ed);
      chk($sformatf("vec%0d_tlast", i), 32'(a_tlast), 32'(vt[i].el));
      chk($sformatf("vec%0d_busy", i), 32'(a_busy), 32'(vt[i].eb));
      chk($sformatf("vec%0d_done", i), 32'(a_done), 32'(vt[i].edn));
      chk($sformatf("vec%0d_bursts", i), a_cnt, vt[i].ecnt);
    end

    // TRIGGERED: trig rises in cycles 0 and 20, bursts of 3 expected in cycles 2-4 and 22-24
    en_a = 1'b0; cfg_limit = 32'd3; cfg_bursts = 32'd0; tready = 1'b1; en_b = 1'b1;
    @(posedge aclk);
    #1;
    chk("trg_wait_busy", 32'(b_busy), 32'd1);
    chk("trg_wait_tvalid", 32'(b_tvalid), 32'd0);
    trig = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      logic ev, el;
      logic [31:0] ed;
      @(posedge aclk);
      #1;
      ev = ((c >= 2) && (c <= 4)) || ((c >= 22) && (c <= 24));
      ed = (c < 20) ? 32'(10 + 3 * (c - 2)) : 32'(10 + 3 * (c - 22));
      el = (c == 4) || (c == 24);
      chk($sformatf("trg_c%0d_tvalid", c), 32'(b_tvalid), 32'(ev));
      chk($sformatf("trg_c%0d_tlast", c), 32'(b_tlast), 32'(el));
      if (ev) chk($sformatf("trg_c%0d_tdata", c), b_tdata, ed);
      if (c == 1 || c == 21) trig = 1'b0;
      if (c == 20) trig = 1'b1;
    end
    chk("trg_bursts", b_cnt, 32'd2);
    chk("trg_busy", 32'(b_busy), 32'd1);
    chk("trg_done", 32'(b_done), 32'd0);
    en_b = 1'b0;

    // 8-bit data path wraps modulo 256
    cfg_start = 32'd250; cfg_step = 32'd4; cfg_limit = 32'd3; cfg_bursts = 32'd1; en_c = 1'b1;
    @(posedge aclk); #1;
    chk("w8_beat0", 32'(c_tdata), 32'd250);
    chk("w8_beat0_last", 32'(c_tlast), 32'd0);
    @(posedge aclk); #1;
    chk("w8_beat1", 32'(c_tdata), 32'd254);
    @(posedge aclk); #1;
    chk("w8_beat2", 32'(c_tdata), 32'd2);
    chk("w8_beat2_last", 32'(c_tlast), 32'd1);
    chk("w8_beat2_valid", 32'(c_tvalid), 32'd1);
    @(posedge aclk); #1;
    chk("w8_done", 32'(c_done), 32'd1);
    chk("w8_tvalid_off", 32'(c_tvalid), 32'd0);
    chk("w8_bursts", c_cnt, 32'd1);
    chk("w8_busy", 32'(c_busy), 32'd0);
    en_c = 1'b0;

    // asynchronous reset in the middle of a burst, then restart on the first edge
    cfg_start = 32'd10; cfg_step = 32'd3; cfg_limit = 32'd4; cfg_bursts = 32'd0; en_a = 1'b1;
    @(posedge aclk); #1;
    chk("ar_run0", a_tdata, 32'd10);
    @(posedge aclk); #1;
    chk("ar_run1", a_tdata, 32'd13);
    #2 areset = 1'b1;
    #1;
    chk("ar_tvalid", 32'(a_tvalid), 32'd0);
    chk("ar_tdata", a_tdata, 32'd0);
    chk("ar_tlast", 32'(a_tlast), 32'd0);
    chk("ar_busy", 32'(a_busy), 32'd0);
    chk("ar_done", 32'(a_done), 32'd0);
    #1 areset = 1'b0;
    @(posedge aclk); #1;
    chk("ar_restart_tvalid", 32'(a_tvalid), 32'd1);
    chk("ar_restart_tdata", a_tdata, 32'd10);
    chk("ar_restart_busy", 32'(a_busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
